// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: state encoding and sizing helpers.
package ex_div_unit_pkg;

  localparam int DATA_BUS_WIDTH = 32;

  typedef logic [DATA_BUS_WIDTH-1:0] data_bus_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Counter must hold 0..DATA_WIDTH-1 with headroom.
  function automatic int div_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division step: shift next dividend bit into the partial remainder, trial-subtract, select.
module ex_div_unit_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] dvd,
  input  logic [DATA_WIDTH-1:0] dsr,
  output logic [DATA_WIDTH-1:0] rem_nxt,
  output logic [DATA_WIDTH-1:0] dvd_nxt
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  ge;
  logic                  diff_unused;

  assign shifted     = {rem, dvd[DATA_WIDTH-1]};
  assign diff        = {1'b0, shifted} - {2'b00, dsr};
  assign ge          = ~diff[DATA_WIDTH+1];
  // A kept difference is always below the divisor, so its top bit is zero.
  assign diff_unused = diff[DATA_WIDTH];
  assign rem_nxt     = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  // Dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
  assign dvd_nxt     = {dvd[DATA_WIDTH-2:0], ge};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient feeds LO, remainder feeds HI.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  cancel,
  input  logic                  stall_ex,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int             CW   = div_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  div_state_e            state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rem_q, dvd_q, dsr_q, rem_nxt, dvd_nxt;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic                  a_neg, b_neg, q_neg, r_neg;
  logic                  go, div0, step, fin;

  assign a_neg = signed_div & dividend[DATA_WIDTH-1];
  assign b_neg = signed_div & divisor[DATA_WIDTH-1];
  // Most negative value negates to itself, which read unsigned is the correct magnitude.
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  assign step = (state == DIV_RUN) & ~cancel;
  assign fin  = step & (cnt == LAST);

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    div0      = 1'b0;
    stall_req = 1'b0;
    done      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start && !cancel) begin
          stall_req = 1'b1;
          if (divisor == '0) begin
            div0      = 1'b1;
            state_nxt = DIV_DONE;
          end else begin
            go        = 1'b1;
            state_nxt = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        stall_req = ~cancel;
        if (cancel)   state_nxt = DIV_IDLE;
        else if (fin) state_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        done = 1'b1;
        if (cancel || !stall_ex) state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  ex_div_unit_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem     (rem_q),
    .dvd     (dvd_q),
    .dsr     (dsr_q),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (go) begin
      cnt   <= '0;
      rem_q <= '0;
      dvd_q <= a_mag;
      dsr_q <= b_mag;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
    end else if (step) begin
      cnt   <= cnt + 1'b1;
      rem_q <= rem_nxt;
      dvd_q <= dvd_nxt;
    end
  end

  // Results are written only when DONE is entered, so they stay stable while EX is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (div0) begin
      quotient  <= '1;
      remainder <= dividend;
    end else if (fin) begin
      quotient  <= q_neg ? -dvd_nxt : dvd_nxt;
      remainder <= r_neg ? -rem_nxt : rem_nxt;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: vector table plus hold, back-to-back, cancel and async-reset sequences.
module tb_ex_div_unit;

  logic        clk, rst, start, signed_div, cancel, stall_ex;
  logic [31:0] dividend, divisor;
  logic        stall_req, done;
  logic [31:0] quotient, remainder;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    string       nm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  ex_div_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .stall_ex   (stall_ex),
    .stall_req  (stall_req),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  // Called at a negedge with the unit in IDLE; returns at the negedge of the DONE cycle with start still high.
  task automatic run_div(input string nm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int elat);
    int lat;
    int sreq;
    lat  = 0;
    sreq = 0;
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    #1;
    while (!done && lat < 100) begin
      if (stall_req) sreq++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_stall_cycles"}, 32'(sreq), 32'(elat));
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_stall_in_done"}, {31'd0, stall_req}, 32'd0);
  endtask

  initial begin
    int dcnt;
    vecs[0]  = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{"div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    vecs[2]  = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
    vecs[3]  = '{"div_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33};
    vecs[4]  = '{"divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33};
    vecs[5]  = '{"div_by_zero",  1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1};
    vecs[6]  = '{"div_m7_m2",    1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33};
    vecs[7]  = '{"divu_big_2",   1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          33};
    vecs[8]  = '{"div_5_7",      1'b1, 32'd5,          32'd7,          32'd0,          32'd5,          33};
    vecs[9]  = '{"divu_min_max", 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33};
    vecs[10] = '{"div_100_m7",   1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          33};

    rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; stall_ex = 1'b0;
    dividend = '0; divisor = '0;
    #1;
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_flags", {30'd0, stall_req, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_div(vecs[i].nm, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);
      start = 1'b0;
      @(negedge clk);
      chk({vecs[i].nm, "_idle"}, {30'd0, stall_req, done}, 32'd0);
    end

    // Held in DONE by a later stall with start still asserted: no restart, outputs frozen.
    run_div("hold", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33);
    stall_ex = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_done", {31'd0, done}, 32'd1);
      chk("hold_q", quotient, 32'd100);
      chk("hold_r", remainder, 32'd0);
      chk("hold_stall_req", {31'd0, stall_req}, 32'd0);
    end
    stall_ex = 1'b0;
    signed_div = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
    @(negedge clk);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    run_div("b2b", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33);
    start = 1'b0;
    @(negedge clk);

    // Cancel at RUN step 10.
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    #1;
    repeat (11) @(negedge clk);
    chk("cancel_running", {31'd0, stall_req}, 32'd1);
    cancel = 1'b1; start = 1'b0;
    #1;
    chk("cancel_stall_drop", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_idle", {30'd0, stall_req, done}, 32'd0);
    chk("cancel_keep_q", quotient, 32'hFFFFFFF2);
    chk("cancel_keep_r", remainder, 32'hFFFFFFFE);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("cancel_no_done", 32'(dcnt), 32'd0);
    run_div("after_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    start = 1'b1; signed_div = 1'b0; dividend = 32'hFFFFFFFF; divisor = 32'd3;
    #1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_flags", {30'd0, stall_req, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div("after_rst", 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 33);
    start = 1'b0;
    @(negedge clk);
    chk("final_idle", {30'd0, stall_req, done}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
